mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 7: data-memory word-address width, giving 2**DEPTH_LOG2 words of 32 bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have inputs regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in, zflag_in, each 1 bit: EX/MEM control bits.
REQ-005 SHALL have inputs branch_result_in [31:0], alures_in [31:0], data2_in [31:0] and instruccion_in [4:0]: branch target, ALU result/address, store data and destination register.
REQ-006 SHALL have inputs stall_in and flush_in, each 1 bit: hold and bubble controls for the MEM/WB register.
REQ-007 SHALL have outputs pcsrc_out [0:0] and branch_target_out [31:0]: the combinational branch decision and its target.
REQ-008 SHALL have registered outputs regwrite_out, memtoreg_out, readdata_out [31:0], alures_out [31:0] and instruccion_out [4:0]: the MEM/WB register.
REQ-009 SHALL have output wb_data_out [31:0]: the combinational write-back value.
REQ-010 SHALL have output misalign_out [0:0]: a registered misalignment flag, present only when the REQ-024 feature is compiled in.

Function
REQ-011 SHALL drive pcsrc_out = branch_in AND zflag_in, and branch_target_out = branch_result_in, combinationally with 0-cycle latency, unaffected by stall_in.
REQ-012 SHALL form the word index from alures_in[DEPTH_LOG2+1:2] and ignore the upper bits, so addresses wrap modulo the memory size.
REQ-013 SHALL write data2_in to mem[index] on posedge clk when memwrite_in=1, flush_in=0 and rst=0.
REQ-014 SHALL read mem[index] combinationally; a read and a write to the same index in the same cycle return the old contents.
REQ-015 SHALL, on posedge clk with flush_in=0 and stall_in=0, load the MEM/WB register as follows (1-cycle latency):
- regwrite_out and memtoreg_out from their inputs;
- alures_out from alures_in and instruccion_out from instruccion_in;
- readdata_out from mem[index] when memread_in=1, else 32'h0.
REQ-016 SHALL hold every MEM/WB register value when stall_in=1 and flush_in=0; memory writes still occur.
REQ-017 SHALL, when flush_in=1, load a bubble into the MEM/WB register (all registered outputs 0) and suppress the memory write; flush_in has priority over stall_in.
REQ-018 SHALL drive wb_data_out = readdata_out when memtoreg_out=1, else alures_out.
REQ-019 SHALL NOT initialise or clear data memory on reset; its contents are undefined until written.

Reset
REQ-020 SHALL, while rst=1 (asynchronous), force regwrite_out, memtoreg_out, readdata_out, alures_out, instruccion_out and misalign_out to 0 immediately.
REQ-021 SHALL suppress memory writes while rst=1, including a write whose edge coincides with reset assertion.
REQ-022 SHALL resume normal operation at the first posedge clk after rst deasserts.
REQ-023 SHALL keep pcsrc_out and branch_target_out purely combinational during reset.

Configuration
REQ-024 SHALL implement the misalignment trap when macro MISALIGN_TRAP_EN is defined:
- an access is misaligned when (memwrite_in OR memread_in)=1 and alures_in[1:0] is not 2'b00;
- a misaligned access suppresses the write, loads readdata_out=0, and sets misalign_out=1 for that MEM/WB entry;
- misalign_out follows the REQ-016 hold and REQ-017 bubble rules.
REQ-025 SHALL, without MISALIGN_TRAP_EN, omit port misalign_out, ignore alures_in[1:0], and perform every access normally.

Verification
REQ-026 SHALL cover a store then a load:
- stimulus: store data2_in=32'hDEADBEEF at alures_in=32'h10, then memread_in=1 at address 32'h10 on the next cycle;
- required: readdata_out=32'hDEADBEEF one cycle later, and wb_data_out=32'hDEADBEEF with memtoreg_in=1.
REQ-027 SHALL cover the branch decision:
- branch_in=1, zflag_in=1, branch_result_in=32'h40 -> pcsrc_out=1 and branch_target_out=32'h40 in the same cycle;
- zflag_in=0 -> pcsrc_out=0.
REQ-028 SHALL cover flush priority:
- stimulus: stall_in=1, flush_in=1, memwrite_in=1 to address 32'h20 with data 32'h5;
- required: all MEM/WB outputs are 0 next cycle, and a later load from 32'h20 does not return 32'h5.
REQ-029 SHALL cover stall hold:
- stimulus: load regwrite_in=1, instruccion_in=5'd9, then stall_in=1 for 3 cycles with changed inputs;
- required: instruccion_out stays 9 and regwrite_out stays 1.
REQ-030 SHALL cover wrap-around: a store to 32'h200 with DEPTH_LOG2=7 followed by a load from 32'h0 returns the stored word.
REQ-031 SHALL cover mid-operation reset:
- stimulus: assert rst between clock edges while regwrite_out=1;
- required: outputs go to 0 without a clock edge, and a store presented during reset is not written.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access and MEM/WB pipeline register.
//
// The stage receives the EX/MEM control and data values and does four things:
//   * resolves the branch decision combinationally (pcsrc_out, branch_target_out);
//   * performs the data-memory access (combinational read, clocked write);
//   * captures the MEM/WB register, honouring stall (hold) and flush (bubble);
//   * selects the write-back value from the registered load data or ALU result.
//
// Optional feature: define MISALIGN_TRAP_EN to add the misalignment trap.
// With the macro defined, an access whose byte offset alures_in[1:0] is
// non-zero has its write suppressed, its load data forced to zero, and the
// registered flag misalign_out raised for that MEM/WB entry. Without it the
// port misalign_out does not exist and the byte offset is simply ignored.
//
// Pipeline controls: there is no valid/ready handshake in this stage. The
// upstream pipeline drives stall_in to hold the MEM/WB register and flush_in
// to replace the incoming entry with a bubble; flush_in wins over stall_in.
//
// The data memory is deliberately not cleared by reset: it models a RAM whose
// contents are undefined until written.

module mem_wb_stage #(
    parameter int DEPTH_LOG2 = 7
) (
    input  logic        clk,
    input  logic        rst,

    // EX/MEM control bits
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        branch_in,
    input  logic        zflag_in,

    // EX/MEM data values
    input  logic [31:0] branch_result_in,
    input  logic [31:0] alures_in,
    input  logic [31:0] data2_in,
    input  logic [4:0]  instruccion_in,

    // Pipeline hold / bubble controls
    input  logic        stall_in,
    input  logic        flush_in,

    // Branch resolution (combinational)
    output logic [0:0]  pcsrc_out,
    output logic [31:0] branch_target_out,

    // MEM/WB register
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] readdata_out,
    output logic [31:0] alures_out,
    output logic [4:0]  instruccion_out,

    // Write-back value (combinational)
    output logic [31:0] wb_data_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic [0:0]  misalign_out
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ------------------------------------------------------------------
    // Data memory storage. No reset: contents are undefined until written.
    // ------------------------------------------------------------------
    logic [31:0] mem [0:DEPTH-1];

    // Word index: byte offset dropped, upper address bits ignored so that
    // addresses beyond the memory size wrap around.
    logic [DEPTH_LOG2-1:0] mem_idx;
    assign mem_idx = alures_in[DEPTH_LOG2+1:2];

    // Asynchronous read port; a same-cycle write to the same word only
    // lands at the clock edge, so the read sees the old contents.
    logic [31:0] mem_rdata;
    assign mem_rdata = mem[mem_idx];

    // ------------------------------------------------------------------
    // Misalignment detection (constant zero when the trap is compiled out).
    // ------------------------------------------------------------------
    logic access_misaligned;

`ifdef MISALIGN_TRAP_EN
    assign access_misaligned = (memwrite_in | memread_in) && (alures_in[1:0] != 2'b00);
`else
    assign access_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control decode for the memory write and the MEM/WB register.
    // ------------------------------------------------------------------

    // A store commits only outside flush and reset, and never when trapped.
    logic mem_we;
    assign mem_we = memwrite_in & ~flush_in & ~rst & ~access_misaligned;

    // The register advances only when neither held nor bubbled.
    logic wb_load;
    assign wb_load = ~flush_in & ~stall_in;

    // Load data for the next MEM/WB entry: zero for non-loads and for
    // trapped accesses.
    logic [31:0] readdata_next;
    assign readdata_next = (memread_in && !access_misaligned) ? mem_rdata : 32'h0;

    // ------------------------------------------------------------------
    // Branch decision: purely combinational, independent of stall and reset.
    // ------------------------------------------------------------------
    assign pcsrc_out         = branch_in & zflag_in;
    assign branch_target_out = branch_result_in;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Memory write port: commits store data at the addressed word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= data2_in;
        end
    end

    // MEM/WB register: async clear, bubble on flush, hold on stall, else load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_out    <= 1'b0;
            memtoreg_out    <= 1'b0;
            readdata_out    <= 32'h0;
            alures_out      <= 32'h0;
            instruccion_out <= 5'd0;
        end else if (flush_in) begin
            regwrite_out    <= 1'b0;
            memtoreg_out    <= 1'b0;
            readdata_out    <= 32'h0;
            alures_out      <= 32'h0;
            instruccion_out <= 5'd0;
        end else if (wb_load) begin
            regwrite_out    <= regwrite_in;
            memtoreg_out    <= memtoreg_in;
            readdata_out    <= readdata_next;
            alures_out      <= alures_in;
            instruccion_out <= instruccion_in;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment flag travels with its MEM/WB entry (same hold/bubble rules).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_out <= 1'b0;
        end else if (flush_in) begin
            misalign_out <= 1'b0;
        end else if (wb_load) begin
            misalign_out <= access_misaligned;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Write-back select: load data or ALU result.
    // ------------------------------------------------------------------
    assign wb_data_out = memtoreg_out ? readdata_out : alures_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: self-checking bench for mem_wb_stage (DEPTH_LOG2 = 7).
// A reference model (word memory + expected MEM/WB entry) produces the
// expected register contents when each cycle is driven; they are queued and
// compared one cycle later when the DUT has registered the entry.

module tb_mem_wb_stage;

    localparam int DL    = 7;
    localparam int WORDS = 128;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        regwrite_in = 1'b0;
    logic        memtoreg_in = 1'b0;
    logic        memwrite_in = 1'b0;
    logic        memread_in  = 1'b0;
    logic        branch_in   = 1'b0;
    logic        zflag_in    = 1'b0;
    logic [31:0] branch_result_in = 32'h0;
    logic [31:0] alures_in   = 32'h0;
    logic [31:0] data2_in    = 32'h0;
    logic [4:0]  instruccion_in = 5'd0;
    logic        stall_in    = 1'b0;
    logic        flush_in    = 1'b0;

    logic [0:0]  pcsrc_out;
    logic [31:0] branch_target_out;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [31:0] readdata_out;
    logic [31:0] alures_out;
    logic [4:0]  instruccion_out;
    logic [31:0] wb_data_out;
`ifdef MISALIGN_TRAP_EN
    logic [0:0]  misalign_out;
`endif

    mem_wb_stage #(.DEPTH_LOG2(DL)) dut (
        .clk               (clk),
        .rst               (rst),
        .regwrite_in       (regwrite_in),
        .memtoreg_in       (memtoreg_in),
        .memwrite_in       (memwrite_in),
        .memread_in        (memread_in),
        .branch_in         (branch_in),
        .zflag_in          (zflag_in),
        .branch_result_in  (branch_result_in),
        .alures_in         (alures_in),
        .data2_in          (data2_in),
        .instruccion_in    (instruccion_in),
        .stall_in          (stall_in),
        .flush_in          (flush_in),
        .pcsrc_out         (pcsrc_out),
        .branch_target_out (branch_target_out),
        .regwrite_out      (regwrite_out),
        .memtoreg_out      (memtoreg_out),
        .readdata_out      (readdata_out),
        .alures_out        (alures_out),
        .instruccion_out   (instruccion_out),
        .wb_data_out       (wb_data_out)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_out      (misalign_out)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  instr;
        logic [31:0] alures;
        logic [31:0] readdata;
    } wb_t;

    logic [70:0]  exp_q[$];
    wb_t          cur_exp = '0;
    logic [31:0]  model_mem [int];
    int           checks = 0;
    int           errors = 0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pops the oldest expected entry and compares it with the registered outputs.
    task automatic compare_out();
        wb_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = wb_t'(exp_q.pop_front());
        check_eq("regwrite_out", {31'd0, regwrite_out}, {31'd0, e.regwrite});
        check_eq("memtoreg_out", {31'd0, memtoreg_out}, {31'd0, e.memtoreg});
        check_eq("instruccion_out", {27'd0, instruccion_out}, {27'd0, e.instr});
        check_eq("alures_out", alures_out, e.alures);
        check_eq("readdata_out", readdata_out, e.readdata);
        check_eq("wb_data_out", wb_data_out, e.memtoreg ? e.readdata : e.alures);
    endtask

    // Drives one cycle of MEM-stage inputs, predicts the MEM/WB entry and checks it.
    task automatic drive_op(input logic rw, input logic mtr, input logic mw, input logic mr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] rd, input logic st, input logic fl);
        wb_t e;
        int  idx;
        regwrite_in    = rw;
        memtoreg_in    = mtr;
        memwrite_in    = mw;
        memread_in     = mr;
        alures_in      = addr;
        data2_in       = data;
        instruccion_in = rd;
        stall_in       = st;
        flush_in       = fl;

        idx = int'((addr >> 2) % WORDS);
        e   = cur_exp;
        if (fl) begin
            e = '0;
        end else if (!st) begin
            e.regwrite = rw;
            e.memtoreg = mtr;
            e.instr    = rd;
            e.alures   = addr;
            if (mr) e.readdata = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            else    e.readdata = 32'h0;
        end
        if (!fl && mw) model_mem[idx] = data;
        cur_exp = e;
        exp_q.push_back(71'(e));

        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Drives the branch inputs and checks the zero-latency decision.
    task automatic drive_branch(input logic b, input logic z, input logic [31:0] tgt);
        branch_in        = b;
        zflag_in         = z;
        branch_result_in = tgt;
        #1;
        check_eq("pcsrc_out", {31'd0, pcsrc_out}, {31'd0, b & z});
        check_eq("branch_target_out", branch_target_out, tgt);
    endtask

    // Checks that every MEM/WB output reads zero right now.
    task automatic check_wb_zero(input string tag);
        check_eq({tag, "_regwrite"}, {31'd0, regwrite_out}, 32'd0);
        check_eq({tag, "_memtoreg"}, {31'd0, memtoreg_out}, 32'd0);
        check_eq({tag, "_instr"}, {27'd0, instruccion_out}, 32'd0);
        check_eq({tag, "_alures"}, alures_out, 32'd0);
        check_eq({tag, "_readdata"}, readdata_out, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] addrs [8];

        // Power-on reset: outputs clear asynchronously.
        #1 rst = 1'b1;
        #1 check_wb_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Branch decision, same cycle.
        drive_branch(1'b1, 1'b1, 32'h40);
        drive_branch(1'b1, 1'b0, 32'h40);
        drive_branch(1'b0, 1'b1, 32'h1234_5678);

        // Store then load, load feeding write-back.
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd4, 1'b0, 1'b0);
        check_eq("store_load_rd", readdata_out, 32'hDEAD_BEEF);
        check_eq("store_load_wb", wb_data_out, 32'hDEAD_BEEF);

        // Same-cycle read and write of one word returns the old contents.
        drive_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0000_1111, 5'd5, 1'b0, 1'b0);
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd6, 1'b0, 1'b0);

        // Flush beats stall and blocks the store.
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0077, 5'd0, 1'b0, 1'b0);
        drive_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0000_0005, 5'd3, 1'b1, 1'b1);
        check_wb_zero("flush");
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd7, 1'b0, 1'b0);
        check_eq("flush_no_store", readdata_out, 32'h0000_0077);

        // Stall holds the entry for three cycles; a store during stall still lands.
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd9, 1'b0, 1'b0);
        drive_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'hABCD_0001, 5'd17, 1'b1, 1'b0);
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, 32'h34, 32'h0, 5'd18, 1'b1, 1'b0);
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h38, 32'h0, 5'd19, 1'b1, 1'b0);
        check_eq("stall_instr", {27'd0, instruccion_out}, 32'd9);
        check_eq("stall_regwrite", {31'd0, regwrite_out}, 32'd1);
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 5'd1, 1'b0, 1'b0);
        check_eq("stall_store", readdata_out, 32'hABCD_0001);

        // Address wrap-around: 0x200 aliases word 0.
        drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0);
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0);
        check_eq("wrap_load", readdata_out, 32'hCAFE_0001);

        // Mid-operation reset: outputs clear between edges; a store under reset is dropped.
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 5'd12, 1'b0, 1'b0);
        check_eq("pre_reset_regwrite", {31'd0, regwrite_out}, 32'd1);
        #2 rst = 1'b1;
        #1 check_wb_zero("async_reset");
        drive_branch(1'b1, 1'b1, 32'h88);
        memwrite_in = 1'b1;
        alures_in   = 32'h10;
        data2_in    = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 rst = 1'b0;
        memwrite_in = 1'b0;
        cur_exp = '0;
        check_wb_zero("reset_held");
        drive_op(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8, 1'b0, 1'b0);
        check_eq("reset_no_store", readdata_out, 32'h0000_1111);

        // Random traffic over a pre-written window of words.
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 32'h40 + 32'(i * 4);
            drive_op(1'b0, 1'b0, 1'b1, 1'b0, addrs[i], $urandom, 5'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            drive_branch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            drive_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     addrs[$urandom_range(0, 7)] + (32'($urandom_range(0, 3)) << (DL + 2)),
                     $urandom, 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
